// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit registered ALU: default width and opcode encodings.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and C/Z/N/V flags from operands and opcode.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             c,
    output logic             z,
    output logic             n,
    output logic             v
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] result_s;
    logic             c_s;
    logic             v_s;

    // Opcode decode; the extra top bit of sum/diff is the carry/borrow.
    always_comb begin
        sum_s    = {1'b0, a} + {1'b0, b};
        diff_s   = {1'b0, a} - {1'b0, b};
        result_s = {WIDTH{1'b0}};
        c_s      = 1'b0;
        v_s      = 1'b0;
        case (op)
            OP_ADD: begin
                result_s = sum_s[WIDTH-1:0];
                c_s      = sum_s[WIDTH];
                v_s      = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result_s = diff_s[WIDTH-1:0];
                c_s      = diff_s[WIDTH];
                v_s      = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: result_s = a & b;
            OP_OR:  result_s = a | b;
            OP_XOR: result_s = a ^ b;
            OP_NOT: result_s = ~a;
            OP_SHL: begin
                result_s = {a[WIDTH-2:0], 1'b0};
                c_s      = a[WIDTH-1];
            end
            OP_SHR: begin
                result_s = {1'b0, a[WIDTH-1:1]};
                c_s      = a[0];
            end
            default: begin
                result_s = {WIDTH{1'b0}};
                c_s      = 1'b0;
                v_s      = 1'b0;
            end
        endcase
    end

    assign result = result_s;
    assign c      = c_s;
    assign v      = v_s;
    assign z      = (result_s == {WIDTH{1'b0}});
    assign n      = result_s[WIDTH-1];

endmodule

// File: rtl/alu_7bits.sv
// Registered ALU wrapper: one-cycle output stage around alu_core with a valid flop.
module alu_7bits
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             out_valid
);

    logic [WIDTH-1:0] result_s;
    logic             c_s;
    logic             z_s;
    logic             n_s;
    logic             v_s;

    logic [WIDTH-1:0] s_r;
    logic             c_r;
    logic             z_r;
    logic             n_r;
    logic             v_r;
    logic             valid_r;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (A),
        .b      (B),
        .op     (op),
        .result (result_s),
        .c      (c_s),
        .z      (z_s),
        .n      (n_s),
        .v      (v_s)
    );

    // Output stage: capture result/flags only on valid inputs, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_r     <= {WIDTH{1'b0}};
            c_r     <= 1'b0;
            z_r     <= 1'b0;
            n_r     <= 1'b0;
            v_r     <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= in_valid;
            if (in_valid) begin
                s_r <= result_s;
                c_r <= c_s;
                z_r <= z_s;
                n_r <= n_s;
                v_r <= v_s;
            end else begin
                s_r <= s_r;
                c_r <= c_r;
                z_r <= z_r;
                n_r <= n_r;
                v_r <= v_r;
            end
        end
    end

    assign S         = s_r;
    assign C         = c_r;
    assign Z         = z_r;
    assign N         = n_r;
    assign V         = v_r;
    assign out_valid = valid_r;

endmodule

// File: tb/tb_alu_7bits.sv
// Scoreboard bench for alu_7bits: directed vectors queue expectations, a monitor checks outputs.
module tb_alu_7bits;

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       in_valid;
    logic [7:0] s;
    logic       c_f;
    logic       z_f;
    logic       n_f;
    logic       v_f;
    logic       out_valid;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_7bits dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (a),
        .B         (b),
        .op        (op),
        .in_valid  (in_valid),
        .S         (s),
        .C         (c_f),
        .Z         (z_f),
        .N         (n_f),
        .V         (v_f),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_S"}, s, 8'h00);
        chk({tag, "_C"}, {7'd0, c_f}, 8'h00);
        chk({tag, "_Z"}, {7'd0, z_f}, 8'h00);
        chk({tag, "_N"}, {7'd0, n_f}, 8'h00);
        chk({tag, "_V"}, {7'd0, v_f}, 8'h00);
        chk({tag, "_valid"}, {7'd0, out_valid}, 8'h00);
    endtask

    task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic [2:0] opv,
                         input logic [7:0] es, input logic ec, input logic ez,
                         input logic en, input logic ev);
        exp_t e;
        @(negedge clk);
        a        = av;
        b        = bv;
        op       = opv;
        in_valid = 1'b1;
        e.s = es; e.c = ec; e.z = ez; e.n = en; e.v = ev;
        exp_q.push_back(e);
    endtask

    // Monitor: every valid output must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 8'h01, 8'h00);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("S", s, e.s);
                chk("C", {7'd0, c_f}, {7'd0, e.c});
                chk("Z", {7'd0, z_f}, {7'd0, e.z});
                chk("N", {7'd0, n_f}, {7'd0, e.n});
                chk("V", {7'd0, v_f}, {7'd0, e.v});
            end
        end
    end

    initial begin
        rst_n    = 1'b1;
        a        = 8'hA5;
        b        = 8'h3C;
        op       = 3'b000;
        in_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_zero("reset");

        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        //       A      B      op      S      C     Z     N     V
        drive(8'h95, 8'h27, 3'b000, 8'hBC, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(8'h95, 8'h27, 3'b001, 8'h6E, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(8'h0A, 8'hD0, 3'b001, 8'h3A, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(8'h0A, 8'hD0, 3'b000, 8'hDA, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(8'hFF, 8'h01, 3'b000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(8'hF0, 8'h3C, 3'b010, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(8'hF0, 8'h3C, 3'b011, 8'hFC, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(8'hF0, 8'h3C, 3'b100, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(8'hF0, 8'h3C, 3'b101, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(8'hF0, 8'h3C, 3'b110, 8'hE0, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(8'h80, 8'h80, 3'b000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(8'hF0, 8'h3C, 3'b111, 8'h78, 1'b0, 1'b0, 1'b0, 1'b0);

        // Hold: inputs change with in_valid low, outputs must keep SHR result.
        @(negedge clk);
        in_valid = 1'b0;
        a        = 8'hFF;
        b        = 8'h01;
        op       = 3'b110;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_S", s, 8'h78);
            chk("hold_C", {7'd0, c_f}, 8'h00);
            chk("hold_N", {7'd0, n_f}, 8'h00);
            chk("hold_valid", {7'd0, out_valid}, 8'h00);
            op = 3'(i);
        end

        // Asynchronous reset mid-operation: pending result discarded.
        a        = 8'h7F;
        b        = 8'h01;
        op       = 3'b000;
        in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        @(posedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_zero("post_release");

        drive(8'h7F, 8'h01, 3'b000, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_drained", 8'(exp_q.size()), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
